// File: rtl/rv32_hpm_counters_if.sv
// CSR access and event-strobe bundle shared between the execute stage and the
// performance-counter bank.
interface rv32_hpm_counters_if #(
  parameter int unsigned NUM_EVENTS = 8
) ();
  logic                  stall_in;
  logic                  read_in;
  logic                  write_in;
  logic [1:0]            write_op_in;
  logic                  src_in;
  logic [11:0]           csr_in;
  logic [31:0]           rs1_value_in;
  logic [31:0]           imm_value_in;
  logic                  instr_retired_in;
  logic [NUM_EVENTS-1:0] events_in;
  logic [31:0]           read_value_out;
  logic                  hit_out;
  logic                  illegal_out;

  modport master (
    output stall_in, read_in, write_in, write_op_in, src_in, csr_in, rs1_value_in,
           imm_value_in, instr_retired_in, events_in,
    input  read_value_out, hit_out, illegal_out
  );

  modport slave (
    input  stall_in, read_in, write_in, write_op_in, src_in, csr_in, rs1_value_in,
           imm_value_in, instr_retired_in, events_in,
    output read_value_out, hit_out, illegal_out
  );
endinterface

// File: rtl/rv32_hpm_counters.sv
// Machine/user performance counters: mcycle, minstret, programmable mhpmcounterN with
// WARL event selectors, mcountinhibit and the read-only user shadows.
module rv32_hpm_counters #(
  parameter int unsigned NUM_COUNTERS  = 4,
  parameter int unsigned COUNTER_WIDTH = 64,
  parameter int unsigned NUM_EVENTS    = 8
) (
  input logic                clk,
  input logic                reset,
  rv32_hpm_counters_if.slave bus
);

  localparam int unsigned W      = COUNTER_WIDTH;
  localparam int unsigned NumHpm = (NUM_COUNTERS > 0) ? NUM_COUNTERS : 1;
  localparam logic [63:0] HpmBits = ((64'd1 << NUM_COUNTERS) - 64'd1) << 3;
  localparam logic [31:0] InhMask = 32'h5 | HpmBits[31:0];

  logic [W-1:0]  cycle_q, cycle_d, instret_q, instret_d;
  logic [W-1:0]  hpm_q [NumHpm];
  logic [W-1:0]  hpm_d [NumHpm];
  logic [4:0]    evsel_q [NumHpm];
  logic [4:0]    evsel_d [NumHpm];
  logic [31:0]   inhibit_q, inhibit_d;

  logic [4:0]    idx;
  logic          hi_half;
  logic          is_mcnt, is_ucnt, is_evt, is_inh, hit, illegal;
  logic [63:0]   cnt_sel;
  logic [4:0]    evt_sel;
  logic [31:0]   rdata, wval, new_value;
  logic          wr_ok, wr_cnt;
  logic [31:0]   ev_vec;

  function automatic logic [63:0] ext64(input logic [W-1:0] v);
    logic [63:0] e;
    e = '0;
    e[W-1:0] = v;
    return e;
  endfunction

  // A write to one half replaces it verbatim and suppresses that cycle's increment.
  function automatic logic [W-1:0] upd(input logic [W-1:0] cur, input logic inc,
                                       input logic wr, input logic hi, input logic [31:0] val);
    logic [63:0] e;
    e = ext64(cur);
    if (wr) begin
      if (hi) e[63:32] = val;
      else    e[31:0]  = val;
      return e[W-1:0];
    end
    return cur + {{(W-1){1'b0}}, inc};
  endfunction

  always_comb begin
    idx     = bus.csr_in[4:0];
    hi_half = bus.csr_in[7];
    is_mcnt = (bus.csr_in[11:8] == 4'hB) && (bus.csr_in[6:5] == 2'b00) && (idx != 5'd1);
    is_ucnt = (bus.csr_in[11:8] == 4'hC) && (bus.csr_in[6:5] == 2'b00);
    is_evt  = (bus.csr_in[11:5] == 7'b0011001) && (idx >= 5'd3);
    is_inh  = (bus.csr_in == 12'h320);
    hit     = is_mcnt | is_ucnt | is_evt | is_inh;
    illegal = (bus.read_in | bus.write_in) && hit && bus.write_in &&
              (bus.csr_in[11:10] == 2'b11);
  end

  // Read mux; index 1 only reaches here through time/timeh, which alias cycle.
  always_comb begin
    cnt_sel = '0;
    evt_sel = '0;
    if (idx == 5'd0 || idx == 5'd1) cnt_sel = ext64(cycle_q);
    else if (idx == 5'd2)           cnt_sel = ext64(instret_q);
    for (int j = 0; j < NUM_COUNTERS; j++) begin
      if (idx == 5'(j + 3)) begin
        cnt_sel = ext64(hpm_q[j]);
        evt_sel = evsel_q[j];
      end
    end
    rdata = '0;
    if (is_mcnt || is_ucnt) rdata = hi_half ? cnt_sel[63:32] : cnt_sel[31:0];
    else if (is_evt)        rdata = {27'd0, evt_sel};
    else if (is_inh)        rdata = inhibit_q;
  end

  always_comb begin
    wval = bus.src_in ? bus.rs1_value_in : bus.imm_value_in;
    case (bus.write_op_in)
      2'b00:   new_value = wval;
      2'b01:   new_value = rdata | wval;
      2'b10:   new_value = rdata & ~wval;
      default: new_value = rdata;
    endcase
    wr_ok  = bus.write_in && !bus.stall_in && hit && !illegal && (bus.write_op_in != 2'b11);
    wr_cnt = wr_ok && is_mcnt;
  end

  always_comb begin
    ev_vec = '0;
    for (int k = 0; k < NUM_EVENTS; k++) ev_vec[k+1] = bus.events_in[k];

    cycle_d   = upd(cycle_q, !inhibit_q[0], wr_cnt && (idx == 5'd0), hi_half, new_value);
    instret_d = upd(instret_q, bus.instr_retired_in && !inhibit_q[2],
                    wr_cnt && (idx == 5'd2), hi_half, new_value);

    for (int j = 0; j < NumHpm; j++) begin
      hpm_d[j]   = hpm_q[j];
      evsel_d[j] = evsel_q[j];
      if (j < NUM_COUNTERS) begin
        // Bit 0 of ev_vec is tied low, so selector 0 never counts.
        hpm_d[j] = upd(hpm_q[j], ev_vec[evsel_q[j]] && !inhibit_q[j+3],
                       wr_cnt && (idx == 5'(j + 3)), hi_half, new_value);
        if (wr_ok && is_evt && (idx == 5'(j + 3))) begin
          evsel_d[j] = (new_value <= NUM_EVENTS) ? new_value[4:0] : 5'd0;
        end
      end
    end

    inhibit_d = (wr_ok && is_inh) ? (new_value & InhMask) : inhibit_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
      inhibit_q <= '0;
      for (int j = 0; j < NumHpm; j++) begin
        hpm_q[j]   <= '0;
        evsel_q[j] <= '0;
      end
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      inhibit_q <= inhibit_d;
      for (int j = 0; j < NumHpm; j++) begin
        hpm_q[j]   <= hpm_d[j];
        evsel_q[j] <= evsel_d[j];
      end
    end
  end

  always_comb begin
    bus.read_value_out = hit ? rdata : 32'd0;
    bus.hit_out        = hit;
    bus.illegal_out    = illegal;
  end

endmodule

// File: tb/tb_rv32_hpm_counters.sv
// Bench for rv32_hpm_counters: directed scenarios plus random CSR traffic checked
// against an address-range reference model of the counter bank.
module tb_rv32_hpm_counters;
  localparam int unsigned NC = 4;
  localparam int unsigned CW = 40;
  localparam int unsigned NE = 8;
  localparam logic [63:0] CMask = (64'd1 << CW) - 64'd1;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  rv32_hpm_counters_if #(.NUM_EVENTS(NE)) bus ();

  rv32_hpm_counters #(
    .NUM_COUNTERS (NC),
    .COUNTER_WIDTH(CW),
    .NUM_EVENTS   (NE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference state: counters indexed by CSR counter number.
  logic [63:0] m_cnt [32];
  logic [31:0] m_evt [32];
  logic [31:0] m_inh;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_impl(input int n);
    return (n == 0) || (n == 2) || (n >= 3 && n < 3 + NC);
  endfunction

  function automatic logic m_hit(input logic [11:0] a);
    return (a == 12'hB00) || (a >= 12'hB02 && a <= 12'hB1F) ||
           (a == 12'hB80) || (a >= 12'hB82 && a <= 12'hB9F) ||
           (a == 12'h320) || (a >= 12'h323 && a <= 12'h33F) ||
           (a >= 12'hC00 && a <= 12'hC1F) || (a >= 12'hC80 && a <= 12'hC9F);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    int n;
    logic [63:0] v;
    if (!m_hit(a)) return 32'd0;
    if (a == 12'h320) return m_inh;
    if (a >= 12'h323 && a <= 12'h33F) begin
      n = int'(a) - 'h320;
      return m_impl(n) ? m_evt[n] : 32'd0;
    end
    n = int'(a) % 32;
    if (n == 1) n = 0;
    v = m_impl(n) ? m_cnt[n] : 64'd0;
    return (a >= 12'hB80 && a < 12'hC00) || (a >= 12'hC80) ? v[63:32] : v[31:0];
  endfunction

  task automatic m_reset();
    for (int n = 0; n < 32; n++) begin
      m_cnt[n] = 64'd0;
      m_evt[n] = 32'd0;
    end
    m_inh = 32'd0;
  endtask

  // Advance the model by one clock using the inputs currently on the bus.
  task automatic m_step();
    logic hit, ill, commit, inc, is_cnt, hi;
    logic [31:0] rd, wv, nv;
    logic [11:0] a;
    logic [63:0] v;
    int sel;
    a      = bus.csr_in;
    hit    = m_hit(a);
    ill    = bus.write_in && hit && (a >= 12'hC00);
    commit = bus.write_in && !bus.stall_in && hit && !ill && (bus.write_op_in != 2'b11);
    rd     = m_read(a);
    wv     = bus.src_in ? bus.rs1_value_in : bus.imm_value_in;
    case (bus.write_op_in)
      2'b00:   nv = wv;
      2'b01:   nv = rd | wv;
      2'b10:   nv = rd & ~wv;
      default: nv = rd;
    endcase
    is_cnt = (a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hB80 && a <= 12'hB9F);
    hi     = (a >= 12'hB80);
    for (int n = 0; n < 32; n++) begin
      if (m_impl(n)) begin
        if (n == 0)      inc = !m_inh[0];
        else if (n == 2) inc = bus.instr_retired_in && !m_inh[2];
        else begin
          sel = int'(m_evt[n]);
          inc = 1'b0;
          if (sel >= 1 && sel <= NE && !m_inh[n]) inc = bus.events_in[sel-1];
        end
        v = m_cnt[n];
        if (commit && is_cnt && (int'(a) % 32 == n)) begin
          if (hi) v[63:32] = nv;
          else    v[31:0]  = nv;
        end else begin
          v = v + 64'(inc);
        end
        m_cnt[n] = v & CMask;
      end
    end
    if (commit && a >= 12'h323 && a <= 12'h33F && m_impl(int'(a) - 'h320))
      m_evt[int'(a) - 'h320] = (nv <= NE) ? nv : 32'd0;
    if (commit && a == 12'h320) m_inh = nv & {25'd0, NC == 4 ? 4'hF : 4'h0, 3'b101};
  endtask

  task automatic tick(input logic rd, input logic wr, input logic [1:0] op,
                      input logic [11:0] a, input logic [31:0] val, input logic stall,
                      input logic ret, input logic [NE-1:0] ev);
    logic s;
    s = 1'($urandom_range(0, 1));
    bus.read_in          = rd;
    bus.write_in         = wr;
    bus.write_op_in      = op;
    bus.csr_in           = a;
    bus.src_in           = s;
    bus.rs1_value_in     = s ? val : $urandom;
    bus.imm_value_in     = s ? $urandom : val;
    bus.stall_in         = stall;
    bus.instr_retired_in = ret;
    bus.events_in        = ev;
    @(negedge clk);
    check_eq($sformatf("rdata@%h", a), 64'(bus.read_value_out), 64'(m_read(a)));
    check_eq($sformatf("hit@%h", a), 64'(bus.hit_out), 64'(m_hit(a)));
    check_eq($sformatf("illegal@%h", a), 64'(bus.illegal_out),
             64'((rd | wr) && wr && m_hit(a) && a >= 12'hC00));
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.read_in  = 1'b1;
    bus.write_in = 1'b0;
    bus.csr_in   = a;
    #1;
    check_eq(tag, 64'(bus.read_value_out), 64'(exp));
  endtask

  logic [11:0] pool [$] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB06,
                            12'hB86, 12'hB07, 12'hB1F, 12'hC00, 12'hC80, 12'hC01, 12'hC81,
                            12'hC02, 12'hC03, 12'hC86, 12'h323, 12'h324, 12'h326, 12'h327,
                            12'h33F, 12'h320, 12'h321, 12'hB01, 12'h300};

  task automatic random_ticks(input int count);
    logic [11:0] a;
    logic [31:0] v;
    for (int i = 0; i < count; i++) begin
      a = pool[$urandom_range(0, pool.size() - 1)];
      v = $urandom;
      if (a >= 12'h323 && a <= 12'h33F && $urandom_range(0, 3) != 0) v = $urandom_range(0, 12);
      if (a == 12'h320 && $urandom_range(0, 1) == 0) v = $urandom_range(0, 3);
      tick(1'($urandom), 1'($urandom_range(0, 2) != 0), 2'($urandom), a, v,
           $urandom_range(0, 3) == 0, 1'($urandom), NE'($urandom));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_reset();
    reset = 1'b1;
    bus.read_in = 0; bus.write_in = 0; bus.write_op_in = 0; bus.src_in = 0;
    bus.csr_in = 0; bus.rs1_value_in = 0; bus.imm_value_in = 0; bus.stall_in = 0;
    bus.instr_retired_in = 0; bus.events_in = '0;
    @(posedge clk);
    #1 reset = 1'b0;

    peek("rst_mcycle", 12'hB00, 32'd0);
    peek("rst_mhpmevent3", 12'h323, 32'd0);
    peek("rst_mcountinhibit", 12'h320, 32'd0);
    repeat (10) tick(1, 0, 2'b00, 12'hB00, 0, 0, 0, '0);
    peek("mcycle_after_10", 12'hB00, 32'd10);

    // Event selection and WARL selector.
    tick(0, 1, 2'b00, 12'h323, 32'd2, 0, 0, '0);
    repeat (5) tick(1, 0, 2'b00, 12'hB03, 0, 0, 0, 8'h02);
    repeat (3) tick(1, 0, 2'b00, 12'hB03, 0, 0, 0, 8'h01);
    peek("hpm3_count", 12'hB03, 32'd5);
    tick(0, 1, 2'b00, 12'h323, 32'd99, 0, 0, '0);
    peek("evsel_warl", 12'h323, 32'd0);
    repeat (3) tick(1, 0, 2'b00, 12'hB03, 0, 0, 0, 8'hFF);
    peek("hpm3_stopped", 12'hB03, 32'd5);

    // Inhibit set/clear.
    tick(0, 1, 2'b01, 12'h320, 32'h5, 0, 0, '0);
    peek("inhibit_rs", 12'h320, 32'h5);
    repeat (4) tick(1, 0, 2'b00, 12'hB00, 0, 0, 1, '0);
    peek("instret_frozen", 12'hB02, 32'd0);
    peek("cycle_frozen", 12'hB00, m_read(12'hB00));
    tick(0, 1, 2'b10, 12'h320, 32'h1, 0, 0, '0);
    peek("inhibit_rc", 12'h320, 32'h4);
    repeat (3) tick(1, 0, 2'b00, 12'hB00, 0, 0, 1, '0);
    peek("instret_still_frozen", 12'hB02, 32'd0);

    // Half writes with no carry, then the following increment carries.
    tick(0, 1, 2'b00, 12'hB00, 32'hFFFF_FFFF, 0, 0, '0);
    tick(0, 1, 2'b00, 12'hB80, 32'h0, 0, 0, '0);
    peek("mcycleh_written", 12'hB80, 32'd0);
    peek("mcycle_written", 12'hB00, 32'hFFFF_FFFF);
    tick(1, 0, 2'b00, 12'hB00, 0, 0, 0, '0);
    peek("mcycle_wrapped_lo", 12'hB00, 32'd0);
    peek("mcycleh_carry", 12'hB80, 32'd1);
    tick(0, 1, 2'b00, 12'hB00, 32'h1234, 1, 0, '0);
    peek("stall_blocks_write", 12'hB00, 32'd1);

    // Width truncation and wrap at 2^CW.
    tick(0, 1, 2'b00, 12'h323, 32'd1, 0, 0, '0);
    tick(0, 1, 2'b00, 12'hB03, 32'hFFFF_FFFF, 0, 0, '0);
    tick(0, 1, 2'b00, 12'hB83, 32'hFF, 0, 0, '0);
    peek("hpm3h_loaded", 12'hB83, 32'hFF);
    tick(1, 0, 2'b00, 12'hB03, 0, 0, 0, 8'h01);
    peek("hpm3_wrap_lo", 12'hB03, 32'd0);
    peek("hpm3_wrap_hi", 12'hB83, 32'd0);
    tick(0, 1, 2'b00, 12'hB83, 32'hFFFF_FFFF, 0, 0, '0);
    peek("hpm3h_trunc", 12'hB83, 32'hFF);

    // Shadow and decode boundaries.
    bus.read_in = 1'b0; bus.write_in = 1'b1; bus.csr_in = 12'hC00;
    #1 check_eq("ill_write_c00", 64'(bus.illegal_out), 64'd1);
    tick(0, 1, 2'b00, 12'hC00, 32'hDEAD_BEEF, 0, 0, '0);
    peek("c00_matches_b00", 12'hC00, m_read(12'hB00));
    check_eq("ill_read_c00", 64'(bus.illegal_out), 64'd0);
    bus.write_in = 1'b1; bus.csr_in = 12'h300;
    #1;
    check_eq("miss_hit", 64'(bus.hit_out), 64'd0);
    check_eq("miss_illegal", 64'(bus.illegal_out), 64'd0);
    check_eq("miss_rdata", 64'(bus.read_value_out), 64'd0);
    peek("unimpl_b1f", 12'hB1F, 32'd0);
    tick(0, 1, 2'b00, 12'h327, 32'd3, 0, 0, '0);
    peek("unimpl_evt", 12'h327, 32'd0);

    random_ticks(600);

    // Asynchronous reset with a write pending.
    bus.write_in = 1'b1; bus.csr_in = 12'hB00; bus.write_op_in = 2'b00;
    #3 reset = 1'b1;
    m_reset();
    peek("async_rst_cycle", 12'hB00, 32'd0);
    peek("async_rst_inh", 12'h320, 32'd0);
    peek("async_rst_evt", 12'h324, 32'd0);
    #1 reset = 1'b0;
    random_ticks(100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
